// File: rtl/proc_pkg.sv
// proc_pkg: shared instruction width, opcode set and sequencer state encoding
package proc_pkg;
  localparam int INSTR_W = 10;
  typedef enum logic [3:0] {
    LOAD, STORE, MV, MVI, ADD, SUB, ANDR, ORR, XORR, NOTR, SHL, SHR, JMP, SIMM
  } opcode_t;
  typedef enum logic [1:0] {FETCH, EXEC, STALL} seq_state_t;
  function automatic logic is_illegal(input logic [3:0] op);
    return op > 4'(SIMM);
  endfunction
endpackage

// File: rtl/step_counter.sv
// step_counter: 2-bit timestep with synchronous clear, increment, hold and wrap detect
module step_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       inc,
  output logic [1:0] t,
  output logic       wrap
);
  assign wrap = inc & ~clear & (t == 2'd3);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) t <= '0;
    else if (clear) t <= '0;
    else if (inc) t <= t + 2'd1;
endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: fetch/execute timestep sequencer with data stall, clear and retired count.
// SINGLE_STEP_EN adds step_req; EXEC/STALL progress then only happens in cycles with step_req high.
module step_sequencer #(
  parameter int INSTR_W = proc_pkg::INSTR_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] data_in,
  input  logic               data_valid,
  output logic               data_ready,
  input  logic               ext,
  input  logic               irin,
  input  logic               clr,
  input  logic               done,
`ifdef SINGLE_STEP_EN
  input  logic               step_req,
`endif
  output logic [INSTR_W-1:0] instr,
  output logic [1:0]         t,
  output logic               busy,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);
  import proc_pkg::*;
  seq_state_t state, state_nx;
  logic step, fetch, bad_op, stall_in, adv, inc, wrap;
`ifdef SINGLE_STEP_EN
  assign step = step_req;
`else
  assign step = 1'b1;
`endif
  assign bad_op = is_illegal(data_in[3:0]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else state <= state_nx;
  always_comb begin
    state_nx = clr ? FETCH :
               fetch & ~bad_op ? EXEC :
               stall_in ? STALL :
               adv & (t == 2'd3) ? FETCH :
               adv ? EXEC : state;
  end
  // a stalled instruction resumes only on a full ext/data_valid handshake
  always_comb begin
    fetch = (state == FETCH) & irin & data_valid & ~clr;
    stall_in = step & ~clr & (state == EXEC) & ext & ~data_valid;
    adv = step & ~clr & ((state == EXEC) ? ~(ext & ~data_valid) : (state == STALL) & ext & data_valid);
    inc = (fetch & ~bad_op) | adv;
    data_ready = ext & ((state != STALL) | data_valid);
    busy = t != 2'd0;
  end
  step_counter u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clr),
    .inc   (inc),
    .t     (t),
    .wrap  (wrap)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instr <= '0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      if (fetch) instr <= data_in;
      illegal <= fetch & bad_op;
      if (wrap & done) retired <= retired + CNT_W'(1);
    end
endmodule
